arm_core: RTL and testbench



---
 rtl/arm_core.sv | 206 ++++++++++++++++++++
 tb/tb_arm_core.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/arm_core.sv
// ============================================================================
// arm_core : single-cycle ARMv4-subset core (DP, LDR/STR, B/BL), Harvard style
// Rev 1.0
// ============================================================================
`default_nettype none

module arm_core (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] ReadData,
  output logic        MemWrite,
  output logic [31:0] PC,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;

  logic [31:0] pc_q, pc_d;
  logic [3:0]  nzcv_q, nzcv_d;
  logic [31:0] rf_q [16];

  logic [31:0] pc_plus4, pc_plus8;
  logic [3:0]  rn, rd, rm, opc;
  logic [31:0] rn_val, rd_val, rm_val;
  logic [31:0] op2_imm, op2_reg, op2;
  logic [31:0] mem_addr, br_target;
  logic [32:0] sum_add, sum_sub;
  logic        cond_ok, n_f, z_f, c_f, v_f;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] s);
    return (x >> s) | (x << (6'd32 - {1'b0, s}));
  endfunction

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;
  assign rn  = Instr[19:16];
  assign rd  = Instr[15:12];
  assign rm  = Instr[3:0];
  assign opc = Instr[24:21];

  // R15 reads see the architectural PC+8.
  assign rn_val = (rn == 4'd15) ? pc_plus8 : rf_q[rn];
  assign rd_val = (rd == 4'd15) ? pc_plus8 : rf_q[rd];
  assign rm_val = (rm == 4'd15) ? pc_plus8 : rf_q[rm];

  assign op2_imm = ror32({24'd0, Instr[7:0]}, {Instr[11:8], 1'b0});

  always_comb begin
    op2_reg = rm_val;
    case (Instr[6:5])
      2'b00:   op2_reg = rm_val << Instr[11:7];
      2'b01:   op2_reg = rm_val >> Instr[11:7];
      2'b10:   op2_reg = $unsigned($signed(rm_val) >>> Instr[11:7]);
      default: op2_reg = ror32(rm_val, Instr[11:7]);
    endcase
  end

  assign op2       = Instr[25] ? op2_imm : op2_reg;
  assign sum_add   = {1'b0, rn_val} + {1'b0, op2};
  assign sum_sub   = {1'b0, rn_val} + {1'b0, ~op2} + 33'd1;
  assign mem_addr  = Instr[23] ? (rn_val + {20'd0, Instr[11:0]})
                               : (rn_val - {20'd0, Instr[11:0]});
  assign br_target = pc_plus8 + {{6{Instr[23]}}, Instr[23:0], 2'b00};

  assign {n_f, z_f, c_f, v_f} = nzcv_q;

  always_comb begin
    cond_ok = 1'b0;
    case (Instr[31:28])
      4'h0: cond_ok = z_f;
      4'h1: cond_ok = !z_f;
      4'h2: cond_ok = c_f;
      4'h3: cond_ok = !c_f;
      4'h4: cond_ok = n_f;
      4'h5: cond_ok = !n_f;
      4'h6: cond_ok = v_f;
      4'h7: cond_ok = !v_f;
      4'h8: cond_ok = c_f && !z_f;
      4'h9: cond_ok = !c_f || z_f;
      4'hA: cond_ok = (n_f == v_f);
      4'hB: cond_ok = (n_f != v_f);
      4'hC: cond_ok = !z_f && (n_f == v_f);
      4'hD: cond_ok = z_f || (n_f != v_f);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  logic        mem_we, rf_we, dp_valid, dp_wr, dp_arith, dp_flags;
  logic [3:0]  wr_idx;
  logic [31:0] wr_data, res;
  logic        res_c, res_v;

  always_comb begin
    pc_d     = pc_plus4;
    nzcv_d   = nzcv_q;
    ALUResult = 32'd0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    wr_idx   = rd;
    wr_data  = 32'd0;
    dp_valid = 1'b0;
    dp_wr    = 1'b1;
    dp_arith = 1'b0;
    res      = 32'd0;
    res_c    = c_f;
    res_v    = v_f;
    dp_flags = Instr[20];
    case (Instr[27:26])
      2'b00: begin
        // bit4 set with I=0 marks register shifts and multiplies: NOP
        dp_valid = Instr[25] || !Instr[4];
        case (opc)
          OP_AND: res = rn_val & op2;
          OP_EOR: res = rn_val ^ op2;
          OP_ORR: res = rn_val | op2;
          OP_MOV: res = op2;
          OP_ADD, OP_CMN: begin
            res      = sum_add[31:0];
            res_c    = sum_add[32];
            res_v    = (rn_val[31] == op2[31]) && (res[31] != rn_val[31]);
            dp_arith = 1'b1;
          end
          OP_SUB, OP_CMP: begin
            res      = sum_sub[31:0];
            res_c    = sum_sub[32];
            res_v    = (rn_val[31] != op2[31]) && (res[31] != rn_val[31]);
            dp_arith = 1'b1;
          end
          default: dp_valid = 1'b0;
        endcase
        if (opc == OP_CMP || opc == OP_CMN) begin
          dp_wr    = 1'b0;
          dp_flags = 1'b1;
        end
        ALUResult = res;
        if (cond_ok && dp_valid) begin
          if (dp_wr) begin
            if (rd == 4'd15) pc_d = res;
            else begin
              rf_we   = 1'b1;
              wr_data = res;
            end
          end
          if (dp_flags)
            nzcv_d = dp_arith ? {res[31], res == 32'd0, res_c, res_v}
                              : {res[31], res == 32'd0, c_f, v_f};
        end
      end
      2'b01: begin
        ALUResult = mem_addr;
        if (cond_ok && !Instr[25] && Instr[24] && !Instr[22] && !Instr[21]) begin
          if (!Instr[20]) mem_we = 1'b1;
          else if (rd == 4'd15) pc_d = ReadData;
          else begin
            rf_we   = 1'b1;
            wr_data = ReadData;
          end
        end
      end
      2'b10: begin
        if (Instr[25]) begin
          ALUResult = br_target;
          if (cond_ok) begin
            pc_d = br_target;
            if (Instr[24]) begin
              rf_we   = 1'b1;
              wr_idx  = 4'd14;
              wr_data = pc_plus4;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q   <= 32'd0;
      nzcv_q <= 4'd0;
      for (int i = 0; i < 16; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      nzcv_q <= nzcv_d;
      if (rf_we) rf_q[wr_idx] <= wr_data;
    end
  end

  // Store enable is masked while reset is held so the wrapper never writes.
  assign MemWrite  = mem_we && !RESET;
  assign PC        = pc_q;
  assign WriteData = rd_val;

endmodule

`default_nettype wire

// File: tb/tb_arm_core.sv
// ============================================================================
// tb_arm_core : directed program with hand-computed expectations for arm_core
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_arm_core;

  logic        CLK;
  logic        RESET;
  logic [31:0] Instr;
  logic [31:0] ReadData;
  logic        MemWrite;
  logic [31:0] PC;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;

  logic [31:0] imem [64];
  logic [31:0] dmem [1024];
  int n_chk;
  int n_pass;

  arm_core dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Instr     (Instr),
    .ReadData  (ReadData),
    .MemWrite  (MemWrite),
    .PC        (PC),
    .ALUResult (ALUResult),
    .WriteData (WriteData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign Instr    = imem[PC[7:2]];
  assign ReadData = dmem[ALUResult[11:2]];

  always @(posedge CLK)
    if (!RESET && MemWrite) dmem[ALUResult[11:2]] <= WriteData;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic next_pc(input logic [31:0] exp_pc);
    @(negedge CLK);
    check("pc", PC, exp_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    RESET  = 1'b1;
    for (int i = 0; i < 64; i++)   imem[i] = 32'hE1A00000;
    for (int i = 0; i < 1024; i++) dmem[i] = 32'd0;
    dmem[128] = 32'h810; dmem[129] = 32'h820; dmem[130] = 32'h830;
    dmem[131] = 32'd5;   dmem[132] = 32'd6;   dmem[133] = 32'h7FFFFFFF;

    imem[0]  = 32'hE59F1204;  // LDR R1,[PC,#0x204]
    imem[1]  = 32'hE59F2204;  // LDR R2,[PC,#0x204]
    imem[2]  = 32'hE59F31F0;  // LDR R3,[PC,#0x1F0]
    imem[3]  = 32'hE59F41F0;  // LDR R4,[PC,#0x1F0]
    imem[4]  = 32'hE0815002;  // ADD R5,R1,R2
    imem[5]  = 32'hE5835004;  // STR R5,[R3,#4]
    imem[6]  = 32'hE2833008;  // ADD R3,R3,#8
    imem[7]  = 32'hE5135004;  // LDR R5,[R3,#-4]
    imem[8]  = 32'hE0426001;  // SUB R6,R2,R1
    imem[9]  = 32'hE5046004;  // STR R6,[R4,#-4]
    imem[10] = 32'hE1510001;  // CMP R1,R1
    imem[11] = 32'h10817002;  // ADDNE R7,R1,R2
    imem[12] = 32'h00818002;  // ADDEQ R8,R1,R2
    imem[13] = 32'hEAFFFFFE;  // B .
    imem[14] = 32'hE5807100;  // STR R7,[R0,#0x100]
    imem[15] = 32'hE5808104;  // STR R8,[R0,#0x104]
    imem[16] = 32'hEB000002;  // BL 0x50
    imem[17] = 32'hE580E108;  // STR R14,[R0,#0x108]
    imem[18] = 32'hE3500001;  // CMP R0,#1
    imem[19] = 32'hEA000003;  // B 0x60
    imem[20] = 32'hE1A0F00E;  // MOV PC,R14
    imem[24] = 32'h4580010C;  // STRMI R0,[R0,#0x10C]
    imem[25] = 32'h25800110;  // STRCS R0,[R0,#0x110]
    imem[26] = 32'hE5909214;  // LDR R9,[R0,#0x214]
    imem[27] = 32'hE299A001;  // ADDS R10,R9,#1
    imem[28] = 32'h6580A114;  // STRVS R10,[R0,#0x114]
    imem[29] = 32'h2580A118;  // STRCS R10,[R0,#0x118]
    imem[30] = 32'h00000000;  // ANDEQ R0,R0,R0
    imem[31] = 32'hEAFFFFFE;  // B .

    @(negedge CLK);
    check("rst_pc", PC, 32'h0);
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    RESET = 1'b0;
    #1;
    check("ldr1_addr", ALUResult, 32'h20C);
    next_pc(32'h4);
    next_pc(32'h8);
    check("ldr3_addr", ALUResult, 32'h200);
    next_pc(32'hC);
    next_pc(32'h10);
    check("add_r5", ALUResult, 32'hB);
    next_pc(32'h14);
    check("str1_addr", ALUResult, 32'h814);
    check("str1_we", {31'd0, MemWrite}, 32'd1);
    check("str1_data", WriteData, 32'hB);
    next_pc(32'h18);
    check("add_imm", ALUResult, 32'h818);
    next_pc(32'h1C);
    check("ldr_neg_addr", ALUResult, 32'h814);
    check("ldr_neg_data", ReadData, 32'hB);
    next_pc(32'h20);
    check("sub_r6", ALUResult, 32'h1);
    next_pc(32'h24);
    check("str2_addr", ALUResult, 32'h81C);
    check("str2_data", WriteData, 32'h1);
    next_pc(32'h28);
    check("cmp_res", ALUResult, 32'h0);
    next_pc(32'h2C);
    check("addne_we", {31'd0, MemWrite}, 32'd0);
    next_pc(32'h30);
    check("addeq_res", ALUResult, 32'hB);
    for (int i = 0; i < 3; i++) begin
      next_pc(32'h34);
      check("loop_we", {31'd0, MemWrite}, 32'd0);
    end
    imem[13] = 32'hE1A00000;
    next_pc(32'h38);
    check("addne_skipped", WriteData, 32'h0);
    check("str_r7_we", {31'd0, MemWrite}, 32'd1);
    next_pc(32'h3C);
    check("addeq_done", WriteData, 32'hB);
    next_pc(32'h40);
    check("bl_target", ALUResult, 32'h50);
    check("bl_we", {31'd0, MemWrite}, 32'd0);
    next_pc(32'h50);
    check("mov_pc_res", ALUResult, 32'h44);
    next_pc(32'h44);
    check("bl_link", WriteData, 32'h44);
    next_pc(32'h48);
    check("cmp01_res", ALUResult, 32'hFFFFFFFF);
    next_pc(32'h4C);
    next_pc(32'h60);
    check("strmi_n_set", {31'd0, MemWrite}, 32'd1);
    next_pc(32'h64);
    check("strcs_c_clr", {31'd0, MemWrite}, 32'd0);
    next_pc(32'h68);
    check("ldr_r9_addr", ALUResult, 32'h214);
    next_pc(32'h6C);
    check("adds_res", ALUResult, 32'h80000000);
    next_pc(32'h70);
    check("strvs_v_set", {31'd0, MemWrite}, 32'd1);
    check("strvs_data", WriteData, 32'h80000000);
    next_pc(32'h74);
    check("strcs_after_adds", {31'd0, MemWrite}, 32'd0);
    next_pc(32'h78);
    check("andeq_we", {31'd0, MemWrite}, 32'd0);
    next_pc(32'h7C);
    next_pc(32'h7C);

    // Flags are N=1,V=1 here; STRPL/STRVC at 0 and 4 only store if reset cleared them.
    imem[0] = 32'h55800120;
    imem[1] = 32'h75800124;
    #2 RESET = 1'b1;
    #1;
    check("async_rst_pc", PC, 32'h0);
    @(negedge CLK);
    check("rst_hold_pc", PC, 32'h0);
    check("rst_hold_we", {31'd0, MemWrite}, 32'd0);
    RESET = 1'b0;
    #1;
    check("post_rst_addr", ALUResult, 32'h120);
    check("post_rst_n_clr", {31'd0, MemWrite}, 32'd1);
    next_pc(32'h4);
    check("post_rst_v_clr", {31'd0, MemWrite}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
